key_display_ctrl: RTL and testbench

- Sequences the keyboard display path.
- Pulls scan-code bytes from the PS/2 receiver FIFO with a ready/ack handshake and tracks make, break (F0) and extended (E0) prefixes.
- Drives nibble values and per-digit enables to six downstream hex 7-segment decoder instances: current key code, extended-key marker, and key-press count.
- Sits between the PS/2 receiver and the decoder bank in the keyboard top level.

---
 rtl/key_display_ctrl_pkg.sv | 24 ++
 rtl/key_display_ctrl_key_code_tracker.sv | 56 +++++
 rtl/key_display_ctrl.sv | 98 +++++++++
 tb/tb_key_display_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_display_ctrl_pkg.sv
// Shared keyboard definitions: prefix bytes, handshake FSM encoding and
// the digit positions used on the hex decoder bank.
package key_display_ctrl_pkg;

    localparam logic [7:0] KBD_BREAK_CODE = 8'hF0;
    localparam logic [7:0] KBD_EXT_CODE   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int DIG_CODE_LO = 0;
    localparam int DIG_CODE_HI = 1;
    localparam int DIG_CNT_LO  = 2;
    localparam int DIG_CNT_HI  = 3;
    localparam int DIG_EXT     = 4;
    localparam int DIG_RSVD    = 5;

    localparam logic [3:0] EXT_GLYPH  = 4'hE;
    localparam logic [3:0] RSVD_GLYPH = 4'h0;

endpackage

// File: rtl/key_display_ctrl_key_code_tracker.sv
// Scan-code interpreter: follows E0/F0 prefixes, remembers the held key
// and counts distinct presses. One byte is consumed per strobe.
module key_code_tracker
    import key_display_ctrl_pkg::*;
#(
    parameter logic [7:0] BREAK_CODE = KBD_BREAK_CODE,
    parameter logic [7:0] EXT_CODE   = KBD_EXT_CODE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       strobe,
    input  logic [7:0] code_byte,
    output logic [7:0] cur_code,
    output logic       cur_ext,
    output logic       pressed,
    output logic [7:0] key_count
);

    logic break_pend;
    logic ext_pend;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_code   <= '0;
            cur_ext    <= 1'b0;
            pressed    <= 1'b0;
            key_count  <= '0;
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
        end else if (strobe) begin
            if (code_byte == BREAK_CODE) begin
                break_pend <= 1'b1;
            end else if (code_byte == EXT_CODE) begin
                ext_pend <= 1'b1;
            end else if (break_pend) begin
                // Releasing a key other than the displayed one is ignored.
                if (code_byte == cur_code && ext_pend == cur_ext)
                    pressed <= 1'b0;
                break_pend <= 1'b0;
                ext_pend   <= 1'b0;
            end else begin
                // Same key while held is typematic repeat, not a new press.
                if (!pressed || code_byte != cur_code || ext_pend != cur_ext) begin
                    cur_code  <= code_byte;
                    cur_ext   <= ext_pend;
                    pressed   <= 1'b1;
                    key_count <= key_count + 8'd1;
                end
                ext_pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/key_display_ctrl.sv
// Pops scan codes from the PS/2 receiver FIFO and drives the six-digit
// hex display: held key code, extended marker and press count.
module key_display_ctrl
    import key_display_ctrl_pkg::*;
#(
    parameter int unsigned ACK_WAIT   = 2,
    parameter logic [7:0]  BREAK_CODE = KBD_BREAK_CODE,
    parameter logic [7:0]  EXT_CODE   = KBD_EXT_CODE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic [7:0]  data,
    output logic        nextdata_n,
    output logic [23:0] hex_val,
    output logic [5:0]  hex_en,
    output logic        pressed,
    output logic [7:0]  key_count
);

    localparam logic [3:0] WAIT_LOAD = 4'(ACK_WAIT);

    state_t     state, state_next;
    logic [3:0] wait_cnt, wait_cnt_next;
    logic [7:0] byte_r;
    logic [7:0] cur_code;
    logic       cur_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            byte_r     <= '0;
            nextdata_n <= 1'b1;
        end else begin
            state      <= state_next;
            wait_cnt   <= wait_cnt_next;
            // Registered strobe: low for exactly the cycle spent in ACK.
            nextdata_n <= (state_next != ACK);
            if (state == IDLE && ready)
                byte_r <= data;
        end
    end

    // NOTE: every output of a combinational block gets a default first so
    // no path through the case statement can infer a latch.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            IDLE: if (ready) state_next = ACK;
            ACK: begin
                wait_cnt_next = WAIT_LOAD;
                state_next    = WAIT;
            end
            WAIT: begin
                wait_cnt_next = wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    key_code_tracker #(
        .BREAK_CODE (BREAK_CODE),
        .EXT_CODE   (EXT_CODE)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .strobe    (state == ACK),
        .code_byte (byte_r),
        .cur_code  (cur_code),
        .cur_ext   (cur_ext),
        .pressed   (pressed),
        .key_count (key_count)
    );

    // Display mapping is a pure function of tracker flops, so it changes
    // only on the edge that closes ACK.
    always_comb begin
        hex_val = '0;
        hex_en  = '0;
        hex_val[4*DIG_CODE_LO +: 4] = cur_code[3:0];
        hex_val[4*DIG_CODE_HI +: 4] = cur_code[7:4];
        hex_val[4*DIG_CNT_LO  +: 4] = key_count[3:0];
        hex_val[4*DIG_CNT_HI  +: 4] = key_count[7:4];
        hex_val[4*DIG_EXT     +: 4] = EXT_GLYPH;
        hex_val[4*DIG_RSVD    +: 4] = RSVD_GLYPH;
        hex_en[DIG_CODE_LO] = pressed;
        hex_en[DIG_CODE_HI] = pressed;
        hex_en[DIG_CNT_LO]  = 1'b1;
        hex_en[DIG_CNT_HI]  = 1'b1;
        hex_en[DIG_EXT]     = pressed & cur_ext;
        hex_en[DIG_RSVD]    = 1'b0;
    end

endmodule

// File: tb/tb_key_display_ctrl.sv
// Directed bench for key_display_ctrl: handshake timing, make/break/extended
// decoding, typematic filtering, press-count wrap and reset during ACK.
module tb_key_display_ctrl;

    localparam int ACK_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        nextdata_n;
    logic [23:0] hex_val;
    logic [5:0]  hex_en;
    logic        pressed;
    logic [7:0]  key_count;

    int n_pass  = 0;
    int n_total = 0;
    int pops    = 0;
    int cyc     = 0;

    key_display_ctrl #(.ACK_WAIT(ACK_WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .data       (data),
        .nextdata_n (nextdata_n),
        .hex_val    (hex_val),
        .hex_en     (hex_en),
        .pressed    (pressed),
        .key_count  (key_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (nextdata_n === 1'b0) pops <= pops + 1;

    // Presents one byte with ready until it is popped, then lets the
    // wait window expire so the next byte starts from IDLE.
    task automatic send_byte(input logic [7:0] b);
        bit found = 0;
        data  = b;
        ready = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (nextdata_n === 1'b0) found = 1;
        end
        ready = 1'b0;
        n_total++;
        if (!found) $display("FAIL pop_timeout byte=%h: no nextdata_n pulse within 20 cycles", b);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (nextdata_n !== 1'b1) $display("FAIL pop_width byte=%h: nextdata_n=%b want 1", b, nextdata_n);
        else n_pass++;
        repeat (ACK_WAIT) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (nextdata_n !== 1'b1) $display("FAIL reset_nextdata_n: got %b want 1", nextdata_n); else n_pass++;
        n_total++;
        if (hex_en !== 6'b001100) $display("FAIL reset_hex_en: got %b want 001100", hex_en); else n_pass++;
        n_total++;
        if (key_count !== 8'h00) $display("FAIL reset_key_count: got %h want 00", key_count); else n_pass++;
        n_total++;
        if (pressed !== 1'b0) $display("FAIL reset_pressed: got %b want 0", pressed); else n_pass++;
        n_total++;
        if (hex_val[15:0] !== 16'h0000) $display("FAIL reset_hex_val: got %h want 0000", hex_val[15:0]); else n_pass++;
    endtask

    task automatic test_single_key();
        int p0 = pops;
        send_byte(8'h1C);
        n_total++;
        if (hex_val[7:0] !== 8'h1C) $display("FAIL single_code: got %h want 1c", hex_val[7:0]); else n_pass++;
        n_total++;
        if (hex_en !== 6'b001111) $display("FAIL single_en: got %b want 001111", hex_en); else n_pass++;
        n_total++;
        if (key_count !== 8'd1) $display("FAIL single_count: got %h want 01", key_count); else n_pass++;
        send_byte(8'hF0);
        send_byte(8'h1C);
        n_total++;
        if (pressed !== 1'b0) $display("FAIL single_release: pressed=%b want 0", pressed); else n_pass++;
        n_total++;
        if (hex_en !== 6'b001100) $display("FAIL single_release_en: got %b want 001100", hex_en); else n_pass++;
        n_total++;
        if (key_count !== 8'd1) $display("FAIL single_count_hold: got %h want 01", key_count); else n_pass++;
        n_total++;
        if (pops - p0 !== 3) $display("FAIL single_pops: got %0d want 3", pops - p0); else n_pass++;
    endtask

    task automatic test_typematic();
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h1C);
            n_total++;
            if (key_count !== 8'd2 || pressed !== 1'b1)
                $display("FAIL typematic_%0d: count=%h pressed=%b want 02/1", i, key_count, pressed);
            else n_pass++;
        end
        // Doubled break prefix still leaves a single pending release.
        send_byte(8'hF0);
        send_byte(8'hF0);
        n_total++;
        if (pressed !== 1'b1) $display("FAIL typematic_f0f0_hold: pressed=%b want 1", pressed); else n_pass++;
        send_byte(8'h1C);
        n_total++;
        if (pressed !== 1'b0 || key_count !== 8'd2)
            $display("FAIL typematic_release: pressed=%b count=%h want 0/02", pressed, key_count);
        else n_pass++;
    endtask

    task automatic test_extended();
        send_byte(8'hE0);
        send_byte(8'h75);
        n_total++;
        if (hex_en !== 6'b011111) $display("FAIL ext_en: got %b want 011111", hex_en); else n_pass++;
        n_total++;
        if (hex_val[19:0] !== 20'hE0375) $display("FAIL ext_val: got %h want e0375", hex_val[19:0]); else n_pass++;
        send_byte(8'hF0);
        send_byte(8'h75);
        n_total++;
        if (pressed !== 1'b1 || hex_en[4] !== 1'b1)
            $display("FAIL ext_plain_release: pressed=%b en4=%b want 1/1", pressed, hex_en[4]);
        else n_pass++;
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        n_total++;
        if (pressed !== 1'b0 || hex_en[4] !== 1'b0 || key_count !== 8'd3)
            $display("FAIL ext_release: pressed=%b en4=%b count=%h want 0/0/03", pressed, hex_en[4], key_count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] fifo [3];
        int t [3];
        int idx = 0;
        int p0;
        fifo[0] = 8'h2B; fifo[1] = 8'hF0; fifo[2] = 8'h2B;
        p0 = pops;
        data = fifo[0];
        ready = 1'b1;
        for (int i = 0; i < 60 && idx < 3; i++) begin
            @(negedge clk);
            if (nextdata_n === 1'b0) begin
                t[idx] = cyc;
                idx++;
                if (idx < 3) data = fifo[idx];
                else ready = 1'b0;
            end
        end
        ready = 1'b0;
        repeat (10) @(negedge clk);
        n_total++;
        if (idx !== 3) $display("FAIL b2b_timeout: got %0d pops want 3", idx); else n_pass++;
        if (idx == 3) begin
            n_total++;
            if (t[1] - t[0] !== 2 + ACK_WAIT) $display("FAIL b2b_gap0: got %0d want %0d", t[1] - t[0], 2 + ACK_WAIT); else n_pass++;
            n_total++;
            if (t[2] - t[1] !== 2 + ACK_WAIT) $display("FAIL b2b_gap1: got %0d want %0d", t[2] - t[1], 2 + ACK_WAIT); else n_pass++;
        end
        n_total++;
        if (pops - p0 !== 3) $display("FAIL b2b_pops: got %0d want 3", pops - p0); else n_pass++;
        n_total++;
        if (key_count !== 8'd4 || pressed !== 1'b0)
            $display("FAIL b2b_state: count=%h pressed=%b want 04/0", key_count, pressed);
        else n_pass++;
    endtask

    task automatic test_wrap_and_reset();
        bit found = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 255; i++) send_byte(i[0] ? 8'h32 : 8'h1C);
        n_total++;
        if (key_count !== 8'hFF) $display("FAIL wrap_ff: got %h want ff", key_count); else n_pass++;
        send_byte(8'h32);
        n_total++;
        if (key_count !== 8'h00 || pressed !== 1'b1)
            $display("FAIL wrap_00: count=%h pressed=%b want 00/1", key_count, pressed);
        else n_pass++;
        data  = 8'h45;
        ready = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (nextdata_n === 1'b0) found = 1;
        end
        n_total++;
        if (!found) $display("FAIL rst_ack_timeout: no pop within 20 cycles"); else n_pass++;
        rst   = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        n_total++;
        if (nextdata_n !== 1'b1) $display("FAIL rst_ack_nextdata_n: got %b want 1", nextdata_n); else n_pass++;
        n_total++;
        if (key_count !== 8'h00 || pressed !== 1'b0 || hex_en !== 6'b001100 || hex_val[15:0] !== 16'h0000)
            $display("FAIL rst_ack_state: count=%h pressed=%b en=%b val=%h want 00/0/001100/0000",
                     key_count, pressed, hex_en, hex_val[15:0]);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h1C);
        n_total++;
        if (key_count !== 8'd1 || hex_val[7:0] !== 8'h1C)
            $display("FAIL rst_recover: count=%h code=%h want 01/1c", key_count, hex_val[7:0]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_typematic();
        test_extended();
        test_back_to_back();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
